// File: rtl/uart_tx_arb.sv
// Two-port round-robin arbiter with a byte FIFO that schedules frames into uart_tx
// through its rdy/data/busy handshake, one frame at a time.
module uart_tx_arb #(
    parameter int FIFO_DEPTH = 8,
    parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req0_valid,
    input  logic [7:0]    i_req0_data,
    output logic          o_req0_ready,
    input  logic          i_req1_valid,
    input  logic [7:0]    i_req1_data,
    output logic          o_req1_ready,
    input  logic          i_flush,
    output logic          o_tx_rdy,
    output logic [7:0]    o_tx_data,
    input  logic          i_tx_busy,
    output logic [LW-1:0] o_fifo_level,
    output logic [15:0]   o_tx_count,
    output logic          o_idle
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [AW:0]   wr_ptr_r;
    logic [AW:0]   rd_ptr_r;
    logic [LW-1:0] level_r;
    logic [7:0]    mem_r [FIFO_DEPTH];
    logic          last_r;
    logic          tx_rdy_r;
    logic          tx_rdy_s;
    logic [7:0]    tx_data_r;
    logic [15:0]   tx_count_r;
    logic          full_s;
    logic          grant_s;
    logic          push_s;
    logic [7:0]    push_data_s;
    logic          pop_s;
    logic          count_inc_s;

    assign full_s       = (level_r == LW'(FIFO_DEPTH));
    assign o_req0_ready = !full_s && !i_flush && (grant_s == 1'b0);
    assign o_req1_ready = !full_s && !i_flush && (grant_s == 1'b1);
    assign push_s       = (i_req0_valid && o_req0_ready) || (i_req1_valid && o_req1_ready);
    assign push_data_s  = grant_s ? i_req1_data : i_req0_data;

    assign o_tx_rdy     = tx_rdy_r;
    assign o_tx_data    = tx_data_r;
    assign o_tx_count   = tx_count_r;
    assign o_fifo_level = level_r;
    assign o_idle       = (state_r == ST_IDLE) && (level_r == LW'(0));

    // Round-robin grant: a lone requester wins; on contention the port not accepted last wins.
    always_comb begin
        grant_s = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            grant_s = ~last_r;
        end else if (i_req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    // Round-robin history; reset to 1 so port 0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            last_r <= 1'b1;
        end else if (push_s) begin
            last_r <= grant_s;
        end else begin
            last_r <= last_r;
        end
    end

    // FIFO storage; contents need no reset since pointers gate every read.
    always_ff @(posedge i_clk) begin
        if (push_s && !i_flush) begin
            mem_r[wr_ptr_r[AW-1:0]] <= push_data_s;
        end
    end

    // FIFO pointers and occupancy; flush overrides any same-cycle push or pop.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            level_r  <= '0;
        end else if (i_flush) begin
            rd_ptr_r <= wr_ptr_r;
            level_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + (AW+1)'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
            end
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + LW'(1);
                2'b01:   level_r <= level_r - LW'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    // Frame sequencer: rdy is only ever driven high in START, so uart_tx cannot double-start.
    always_comb begin
        state_s     = state_r;
        tx_rdy_s    = 1'b0;
        pop_s       = 1'b0;
        count_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((level_r != LW'(0)) && !i_tx_busy && !i_flush) begin
                    pop_s    = 1'b1;
                    tx_rdy_s = 1'b1;
                    state_s  = ST_START;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_START: begin
                if (i_tx_busy) begin
                    tx_rdy_s = 1'b0;
                    state_s  = ST_WAIT_DONE;
                end else begin
                    tx_rdy_s = 1'b1;
                    state_s  = ST_START;
                end
            end
            ST_WAIT_DONE: begin
                if (!i_tx_busy) begin
                    count_inc_s = 1'b1;
                    state_s     = ST_IDLE;
                end else begin
                    state_s     = ST_WAIT_DONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and registered handshake outputs; tx_data only moves on a pop.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_r    <= ST_IDLE;
            tx_rdy_r   <= 1'b0;
            tx_data_r  <= 8'h00;
            tx_count_r <= 16'h0000;
        end else begin
            state_r  <= state_s;
            tx_rdy_r <= tx_rdy_s;
            if (pop_s) begin
                tx_data_r <= mem_r[rd_ptr_r[AW-1:0]];
            end
            if (count_inc_s) begin
                tx_count_r <= tx_count_r + 16'd1;
            end
        end
    end

endmodule

// File: doc/uart_tx_arb.md
# uart_tx_arb

Two-port arbiter and scheduler for the MMIO UART transmitter. It accepts bytes from two requesters (port 0: CPU MMIO store path; port 1: debug/trace source) using round-robin arbitration and buffers them in a FIFO. It sequences the `uart_tx` engine through its `i_rdy`/`i_data`/`o_busy` handshake, one frame at a time. The block sits between the MMIO decode and `uart_tx`, and shares `uart_tx`'s clock and reset.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of two and ≥2.
- `LW`, default $clog2(FIFO_DEPTH)+1: width of the level output. Derived; do not override.

Ports:
- `i_clk` in 1: clock; all logic on the rising edge.
- `i_rst` in 1: reset, asynchronous, active-low.
- `i_req0_valid` in 1: port 0 byte offered.
- `i_req0_data` in 8: port 0 byte.
- `o_req0_ready` out 1: port 0 byte accepted this cycle if valid.
- `i_req1_valid` in 1: port 1 byte offered.
- `i_req1_data` in 8: port 1 byte.
- `o_req1_ready` out 1: port 1 byte accepted this cycle if valid.
- `i_flush` in 1: synchronous FIFO flush.
- `o_tx_rdy` out 1: drives `uart_tx.i_rdy`.
- `o_tx_data` out 8: drives `uart_tx.i_data`.
- `i_tx_busy` in 1: from `uart_tx.o_busy`.
- `o_fifo_level` out LW: current FIFO occupancy, 0..FIFO_DEPTH.
- `o_tx_count` out 16: completed frames, wraps 0xFFFF→0.
- `o_idle` out 1: FIFO empty and FSM in IDLE.

## Operation
- Reset (i_rst low, any time, including mid-frame): FIFO empty, pointers 0, FSM IDLE, o_tx_rdy=0, o_tx_data=0, o_tx_count=0, o_fifo_level=0, o_idle=1, round-robin pointer favours port 0.
- Arbitration (combinational ready):
  - full = (level == FIFO_DEPTH), evaluated on the registered level.
  - With only one port valid, that port is granted.
  - With both valid, the port not most recently accepted is granted; after reset, port 0 wins.
  - o_reqN_ready = !full && !i_flush && grant==N. At most one push per cycle.
  - The round-robin pointer updates only on an accepted push.
- FIFO:
  - Push on valid&&ready, writing the granted port's data.
  - Pop is performed by the FSM.
  - Simultaneous push and pop: level unchanged, both take effect.
  - Pointers carry an extra wrap bit.
  - Push while full is impossible because ready is 0.
- Flush:
  - i_flush=1 sets pointers equal and level=0 at the next edge. It overrides any same-cycle push or pop.
  - An in-flight frame is not aborted; o_tx_data stays held and the FSM continues.
- FSM states:
  - IDLE: if level≠0 && !i_tx_busy && !i_flush: pop the head into o_tx_data, set o_tx_rdy=1, go to START. Otherwise stay.
  - START: hold o_tx_rdy=1 until i_tx_busy==1 is sampled. Then set o_tx_rdy=0 and go to WAIT_DONE.
  - WAIT_DONE: when i_tx_busy==0 is sampled, increment o_tx_count and go to IDLE.
- o_tx_data is registered and changes only on a pop. It stays stable from the rising of o_tx_rdy until the next pop, which covers the whole frame including the stop bit.
- o_idle = (state==IDLE) && (level==0).

## Timing
- Empty FIFO, IDLE, busy low:
  - Byte accepted at edge k.
  - Edge k+1: pop, o_tx_rdy=1.
  - Edge k+2: uart_tx samples rdy; busy rises.
  - Edge k+3: o_tx_rdy=0.
  - o_tx_rdy is therefore high exactly 2 cycles per frame when uart_tx is idle.
- Frame completion:
  - o_tx_count increments at the edge that samples busy low.
  - The next pop and rdy occur one edge later. Minimum gap from busy-low sample to next o_tx_rdy is 1 cycle.
- o_tx_rdy must never be high while the FSM is in IDLE or WAIT_DONE. This guarantees uart_tx never starts a duplicate frame.
- Ready paths are combinational from valid and registered state. There is no combinational path from i_tx_busy to ready.

## Test plan
- Single byte: port 0 writes 0xA5 with uart_tx at 50 MHz / 115200 baud.
  - o_tx_rdy is high exactly 2 cycles.
  - o_tx_data=0xA5 is held until frame end.
  - o_tx_count goes 0→1, then o_idle=1.
- Round-robin: both ports hold valid continuously, port 0 sending 0x10..0x13 and port 1 sending 0x20..0x23.
  - Enqueue order is 0x10,0x20,0x11,0x21,…
  - Transmit order matches enqueue order.
- Full FIFO (FIFO_DEPTH=8): push 9 bytes while the first frame is in flight.
  - Level reaches 8 and ready drops to 0.
  - Ready reasserts the cycle after the next pop.
  - All 9 bytes are transmitted in order.
- Simultaneous push and pop at level 1: level stays 1; the popped byte is the older one.
- Flush mid-frame with level=5: level becomes 0 next cycle, the current frame completes, o_tx_count increments by 1 only, and no further frames start.
- Reset mid-frame in START/WAIT_DONE: all outputs return to reset values. After release, a new byte 0x3C transmits normally with count=1.
